// File: rtl/candy_if.sv
// ---------------------------------------------------------------------------
// candy_if : instruction fetch stage feeding candy_id
//
// Owns the PC and issues word reads to instruction memory over a req/ack
// handshake, at most one outstanding. Fetched {pc, inst} pairs go into a
// small FIFO. The FIFO head is presented to decode through registered
// outputs. Stall holds the output. Redirect loads a new PC and flushes
// everything buffered or in flight.
//
// Handshake (valid/ready style): imem_req is the valid and imem_ack is the
// ready/response. Once imem_req is raised, imem_req and imem_addr hold
// steady until the cycle imem_ack=1; imem_rdata is sampled in that cycle.
// A redirect never withdraws a live request. It is completed and its data
// dropped (DROP state).
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   imem_req/addr    read request and word address (out)
//   imem_ack/rdata   request complete, instruction word (in)
//   redirect_valid   load redirect_pc, flush buffered and in-flight fetches
//   redirect_pc      redirect target
//   stall            decode not accepting; hold the current output
//   inst_valid       inst/inst_pc carry a real instruction
//   inst, inst_pc    instruction and its PC; both 0 when inst_valid=0
//   dbg_state        FSM state: 0=IDLE 1=WAIT 2=DROP
// ---------------------------------------------------------------------------
module candy_if #(
  parameter int unsigned     ADDR_W     = 16,
  parameter int unsigned     INST_W     = 24,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              stall,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [1:0]        dbg_state
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                req_q, req_d;

  logic [ADDR_W-1:0]   fifo_pc_q   [FIFO_DEPTH];
  logic [ADDR_W-1:0]   fifo_pc_d   [FIFO_DEPTH];
  logic [INST_W-1:0]   fifo_inst_q [FIFO_DEPTH];
  logic [INST_W-1:0]   fifo_inst_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic                valid_q, valid_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic [ADDR_W-1:0]   inst_pc_q, inst_pc_d;

  logic                push;
  logic                pop;
  logic [CNT_W:0]      occ;        // FIFO occupancy after this edge's push/pop
  logic                can_issue;  // room for one more word once it returns

  // Data is kept only for a live (non-dropped) request completing without a
  // simultaneous redirect. Pop never happens on a redirect cycle: the flush
  // takes precedence.
  assign push = (state_q == S_WAIT) && imem_ack && !redirect_valid;
  assign pop  = (count_q != '0) && !stall && !redirect_valid;

  // pop implies count_q >= 1, so this cannot underflow.
  assign occ = {1'b0, count_q} + {{CNT_W{1'b0}}, push} - {{CNT_W{1'b0}}, pop};
  // After this edge nothing else is in flight, so a new request is allowed
  // while occupancy leaves one free slot for its data.
  assign can_issue = occ < (CNT_W + 1)'(FIFO_DEPTH);

  // -------------------------------------------------------------------------
  // Fetch FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    req_d   = req_q;
    case (state_q)
      S_IDLE: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end else if (can_issue) begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          if (redirect_valid) begin
            pc_d    = redirect_pc;
            req_d   = 1'b0;
            state_d = S_IDLE;
          end else begin
            // PC tracks the next word to fetch; wraps naturally at 2^ADDR_W.
            pc_d = addr_q + ADDR_W'(1);
            if (can_issue) begin
              addr_d = addr_q + ADDR_W'(1);
            end else begin
              req_d   = 1'b0;
              state_d = S_IDLE;
            end
          end
        end else if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end
        if (imem_ack) begin
          req_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Fetch buffer and registered outputs
  // -------------------------------------------------------------------------
  always_comb begin
    fifo_pc_d   = fifo_pc_q;
    fifo_inst_d = fifo_inst_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    if (redirect_valid) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        fifo_pc_d[wr_ptr_q]   = addr_q;
        fifo_inst_d[wr_ptr_q] = imem_rdata;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = occ[CNT_W-1:0];
    end
    // Outputs register the post-edge head, so a push into an empty FIFO is
    // visible the cycle after the ack.
    valid_d   = (count_d != '0);
    inst_d    = valid_d ? fifo_inst_d[rd_ptr_d] : '0;
    inst_pc_d = valid_d ? fifo_pc_d[rd_ptr_d]   : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      addr_q    <= RESET_PC;
      req_q     <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      req_q     <= req_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  // Storage needs no reset: entries are only observed through count/pointers.
  always_ff @(posedge clk) begin
    fifo_pc_q   <= fifo_pc_d;
    fifo_inst_q <= fifo_inst_d;
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign inst_valid = valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign dbg_state  = state_q;

  // The credit rule must never let a word arrive with the buffer full.
  push_when_full: assert property (@(posedge clk) disable iff (rst)
    !(push && (count_q == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_candy_if.sv
// ---------------------------------------------------------------------------
// tb_candy_if : self-checking bench for candy_if
//
// A memory responder answers each request after mem_lat cycles with
// 24'h100000 + addr. A stream model tracks the PC decode must see next:
// RESET_PC after reset, redirect_pc after a redirect, +1 per consumed
// instruction. It checks every cycle that the shown instruction is exactly
// that one, that bubbles are zero, that a flush empties the output, and that
// requests hold steady until acked. Directed checks pin literal values.
// ---------------------------------------------------------------------------
module tb_candy_if;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [23:0] imem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        stall;
  logic        inst_valid;
  logic [23:0] inst;
  logic [15:0] inst_pc;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  candy_if dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] mem_word(input logic [15:0] a);
    return 24'h100000 + {8'h00, a};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // ---------------- memory responder ----------------
  int mem_lat     = 0;
  bit manual_mode = 0;
  int mem_cnt     = 0;

  always @(posedge clk) begin
    #2;
    if (manual_mode) begin
      mem_cnt = 0;
    end else if (imem_req) begin
      imem_ack   = (mem_cnt == mem_lat);
      imem_rdata = mem_word(imem_addr);
      mem_cnt    = imem_ack ? 0 : mem_cnt + 1;
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 24'h0;
      mem_cnt    = 0;
    end
  end

  // ---------------- stream model / compare process ----------------
  bit          model_on      = 0;
  logic [15:0] exp_pc        = 16'h0;
  bit          flush_pending = 0;
  bit          hs_pending    = 0;
  logic [15:0] hs_addr       = 16'h0;

  always @(negedge clk) begin
    if (model_on) begin
      if (inst_valid === 1'b1) begin
        check("stream_pc", 32'(inst_pc), 32'(exp_pc));
        check("stream_inst", 32'(inst), 32'(mem_word(exp_pc)));
      end else begin
        check("bubble_valid", 32'(inst_valid), 32'h0);
        check("bubble_inst", 32'(inst), 32'h0);
        check("bubble_pc", 32'(inst_pc), 32'h0);
      end
      if (flush_pending) check("flush_empty", 32'(inst_valid), 32'h0);
      if (hs_pending) begin
        check("hold_req", 32'(imem_req), 32'h1);
        check("hold_addr", 32'(imem_addr), 32'(hs_addr));
      end
      if (rst) exp_pc = 16'h0000;
      else if (redirect_valid) exp_pc = redirect_pc;
      else if (inst_valid && !stall) exp_pc = exp_pc + 16'h1;
      flush_pending = rst || redirect_valid;
      hs_pending    = imem_req && !imem_ack && !rst;
      hs_addr       = imem_addr;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    tick();
    model_on = 1;
    repeat (n - 1) tick();
    rst = 1'b0;
  endtask

  task automatic redirect(input logic [15:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst            = 1'b1;
    imem_ack       = 1'b0;
    imem_rdata     = 24'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0;
    stall          = 1'b0;

    // 1: zero-wait memory, one instruction per cycle
    mem_lat = 0;
    do_reset(3);
    check("t1_rst_req", 32'(imem_req), 32'h0);
    check("t1_rst_addr", 32'(imem_addr), 32'h0);
    check("t1_rst_valid", 32'(inst_valid), 32'h0);
    check("t1_rst_state", 32'(dbg_state), 32'h0);
    tick();
    check("t1_first_req", 32'(imem_req), 32'h1);
    check("t1_first_addr", 32'(imem_addr), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t1_valid", 32'(inst_valid), 32'h1);
      check("t1_pc", 32'(inst_pc), 32'(i));
      check("t1_inst", 32'(inst), 32'h100000 + 32'(i));
    end

    // 2: stall from start fills exactly two entries, then drains in order
    stall = 1'b1;
    do_reset(3);
    repeat (6) tick();
    check("t2_req_low", 32'(imem_req), 32'h0);
    check("t2_state_idle", 32'(dbg_state), 32'h0);
    check("t2_hold_pc", 32'(inst_pc), 32'h0);
    stall = 1'b0;
    tick();
    check("t2_pc1", 32'(inst_pc), 32'h1);
    check("t2_resume_req", 32'(imem_req), 32'h1);
    check("t2_resume_addr", 32'(imem_addr), 32'h2);
    tick();
    check("t2_pc2", 32'(inst_pc), 32'h2);
    tick();
    check("t2_pc3", 32'(inst_pc), 32'h3);

    // 3: redirect while a slow request is outstanding
    mem_lat = 3;
    do_reset(2);
    redirect(16'h0005);
    tick();
    check("t3_req", 32'(imem_req), 32'h1);
    check("t3_addr5", 32'(imem_addr), 32'h5);
    redirect(16'h0040);
    check("t3_drop_state", 32'(dbg_state), 32'h2);
    check("t3_drop_addr", 32'(imem_addr), 32'h5);
    tick();
    tick();
    check("t3_ack_addr", 32'(imem_addr), 32'h5);
    tick();
    mem_lat = 0;
    check("t3_idle_req", 32'(imem_req), 32'h0);
    tick();
    check("t3_new_req", 32'(imem_req), 32'h1);
    check("t3_new_addr", 32'(imem_addr), 32'h40);
    tick();
    check("t3_first_pc", 32'(inst_pc), 32'h40);
    check("t3_first_valid", 32'(inst_valid), 32'h1);

    // 4: redirect in the same cycle as an ack, with an entry buffered
    stall   = 1'b1;
    mem_lat = 0;
    do_reset(2);
    tick();
    tick();
    check("t4_pre_valid", 32'(inst_valid), 32'h1);
    check("t4_pre_addr", 32'(imem_addr), 32'h1);
    redirect(16'h0200);
    stall = 1'b0;
    check("t4_flush_valid", 32'(inst_valid), 32'h0);
    check("t4_flush_inst", 32'(inst), 32'h0);
    check("t4_req_low", 32'(imem_req), 32'h0);
    tick();
    check("t4_req_target", 32'(imem_addr), 32'h200);
    check("t4_req_high", 32'(imem_req), 32'h1);
    tick();
    check("t4_first_pc", 32'(inst_pc), 32'h200);

    // 5: PC wrap at the top of the address space
    do_reset(2);
    redirect(16'hFFFF);
    tick();
    check("t5_req_addr", 32'(imem_addr), 32'hFFFF);
    tick();
    check("t5_pc_ffff", 32'(inst_pc), 32'hFFFF);
    tick();
    check("t5_pc_wrap", 32'(inst_pc), 32'h0);
    check("t5_inst_wrap", 32'(inst), 32'h100000);

    // 6: reset during WAIT, then a stale ack with no request outstanding
    mem_lat = 20;
    do_reset(2);
    tick();
    tick();
    check("t6_wait_state", 32'(dbg_state), 32'h1);
    rst = 1'b1;
    tick();
    rst         = 1'b0;
    manual_mode = 1;
    imem_ack    = 1'b1;
    imem_rdata  = 24'hBAD000;
    check("t6_rst_req", 32'(imem_req), 32'h0);
    check("t6_rst_valid", 32'(inst_valid), 32'h0);
    check("t6_rst_addr", 32'(imem_addr), 32'h0);
    tick();
    imem_ack    = 1'b0;
    manual_mode = 0;
    mem_lat     = 0;
    check("t6_stale_valid", 32'(inst_valid), 32'h0);
    check("t6_restart_req", 32'(imem_req), 32'h1);
    check("t6_restart_addr", 32'(imem_addr), 32'h0);
    tick();
    check("t6_first_pc", 32'(inst_pc), 32'h0);
    check("t6_first_inst", 32'(inst), 32'h100000);
    repeat (3) tick();

    model_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Guard against a hung sequence.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
